// File: rtl/audio_sample_accumulator.sv
// Windowed signed sample accumulator with sticky done flag and ack/start control.
// Ports: clk, reset_n (sync, active-low), start, ack, sample_in/valid/ready,
// acc_sum, acc_done, busy, sample_count. Option: ACC_SATURATE_EN saturates adds.
module audio_sample_accumulator #(
  parameter int SAMPLE_W = 16,
  parameter int WINDOW   = 256,
  parameter int ACC_W    = 24,
  parameter int CNT_W    = 9
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                ack,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic [ACC_W-1:0]    acc_sum,
  output logic                acc_done,
  output logic                busy,
  output logic [CNT_W-1:0]    sample_count
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             rdy_q, rdy_d;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] raw;
  logic [ACC_W-1:0] add;
  logic             hs;

  assign ext = {{(ACC_W-SAMPLE_W){sample_in[SAMPLE_W-1]}}, sample_in};
  assign raw = sum_q + ext;
  assign hs  = sample_valid && rdy_q;

`ifdef ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic ovf;
  // Overflow only when both operands share a sign the result lost.
  assign ovf = (sum_q[ACC_W-1] == ext[ACC_W-1]) &&
               (raw[ACC_W-1] != sum_q[ACC_W-1]);
  assign add = ovf ? (sum_q[ACC_W-1] ? SMIN : SMAX) : raw;
`else
  assign add = raw;
`endif

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (hs) begin
          sum_d = add;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        // Start alone never overwrites an unacknowledged result.
        if (ack) begin
          done_d = 1'b0;
          if (start) begin
            state_d = ACCUM;
            sum_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign sample_ready = rdy_q;
  assign busy         = rdy_q;
  assign acc_sum      = sum_q;
  assign acc_done     = done_q;
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_audio_sample_accumulator.sv
// Scoreboard bench for audio_sample_accumulator: WINDOW=4 at ACC_W=24 and 17,
// plus a default-size instance for the mid-window reset case.
module tb_audio_sample_accumulator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        ack;
  logic [15:0] sample_in;
  logic        sample_valid;

  logic        a_rdy, a_done, a_busy;
  logic [23:0] a_sum;
  logic [2:0]  a_cnt;
  logic        n_rdy, n_done, n_busy;
  logic [16:0] n_sum;
  logic [2:0]  n_cnt;
  logic        d_rdy, d_done, d_busy;
  logic [23:0] d_sum;
  logic [8:0]  d_cnt;

  always #5 clk = ~clk;

  audio_sample_accumulator #(
    .SAMPLE_W(16), .WINDOW(4), .ACC_W(24), .CNT_W(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ack(ack),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(a_rdy), .acc_sum(a_sum), .acc_done(a_done),
    .busy(a_busy), .sample_count(a_cnt)
  );

  audio_sample_accumulator #(
    .SAMPLE_W(16), .WINDOW(4), .ACC_W(17), .CNT_W(3)
  ) dut_n (
    .clk(clk), .reset_n(reset_n), .start(start), .ack(ack),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(n_rdy), .acc_sum(n_sum), .acc_done(n_done),
    .busy(n_busy), .sample_count(n_cnt)
  );

  audio_sample_accumulator dut_d (
    .clk(clk), .reset_n(reset_n), .start(start), .ack(ack),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(d_rdy), .acc_sum(d_sum), .acc_done(d_done),
    .busy(d_busy), .sample_count(d_cnt)
  );

  typedef struct {
    int sum;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_sum = 0;
  int   m_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_sum = 0;
    m_cnt = 0;
  endtask

  task automatic send(input int v, input int gap);
    int k;
    logic r;
    sample_in    = 16'(v);
    sample_valid = 1'b1;
    for (k = 0; k < 20; k++) begin
      r = a_rdy;
      tick();
      if (r) break;
    end
    if (k == 20) check("hs_timeout", 0, 1);
    sample_valid = 1'b0;
    m_sum += v;
    m_cnt++;
    if (m_cnt == 4) begin
      sb.push_back('{sum: m_sum, cnt: 4});
      m_sum = 0;
      m_cnt = 0;
    end
    repeat (gap) tick();
  endtask

  task automatic pop(input string tag);
    int   n;
    int   s;
    exp_t e;
    for (n = 0; n < 50; n++) begin
      if (a_done) break;
      tick();
    end
    check({tag, "_done"}, n, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb"}, 0, 1);
    end else begin
      e = sb.pop_front();
      s = $signed(a_sum);
      check({tag, "_sum"}, s, e.sum);
      check({tag, "_cnt"}, int'(a_cnt), e.cnt);
      check({tag, "_rdy"}, int'(a_rdy), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    reset_n      = 1'b0;
    start        = 1'b0;
    ack          = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    repeat (2) tick();
    check("rst_sum", int'(a_sum), 0);
    check("rst_done", int'(a_done), 0);
    check("rst_rdy", int'(a_rdy), 0);
    check("rst_busy", int'(a_busy), 0);
    check("rst_cnt", int'(a_cnt), 0);
    reset_n = 1'b1;
    tick();

    // mid-window reset on the default-size instance
    go();
    check("d_busy", int'(d_busy), 1);
    sample_in    = 16'd100;
    sample_valid = 1'b1;
    repeat (10) tick();
    sample_valid = 1'b0;
    check("d_cnt10", int'(d_cnt), 10);
    check("d_sum10", int'(d_sum), 1000);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("d_rst_sum", int'(d_sum), 0);
    check("d_rst_cnt", int'(d_cnt), 0);
    check("d_rst_rdy", int'(d_rdy), 0);
    check("d_rst_busy", int'(d_busy), 0);
    check("d_rst_done", int'(d_done), 0);
    tick();

    // basic back-to-back window
    go();
    check("b_rdy", int'(a_rdy), 1);
    check("b_cnt0", int'(a_cnt), 0);
    for (int i = 1; i <= 4; i++) send(i, 0);
    check("b_lat", int'(a_done), 1);
    pop("basic");

    // ack returns to IDLE, sum held
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_done", int'(a_done), 0);
    check("ack_hold", int'(a_sum), 10);
    check("ack_rdy", int'(a_rdy), 0);

    // signed extremes with gaps
    go();
    send(-32768, 3);
    send(32767, 3);
    send(-1, 3);
    send(5, 3);
    pop("gaps");
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // start during ACCUM is ignored
    go();
    send(-7, 0);
    send(-8, 0);
    start = 1'b1;
    send(9, 0);
    start = 1'b0;
    check("st_acc_cnt", int'(a_cnt), 3);
    send(20, 0);
    pop("st_acc");

    // start alone in DONE, with valid held high
    start        = 1'b1;
    sample_in    = 16'd77;
    sample_valid = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    sample_valid = 1'b0;
    check("st_done_flag", int'(a_done), 1);
    check("st_done_sum", int'(a_sum), 14);
    check("bp_done_cnt", int'(a_cnt), 4);

    // ack and start together
    ack   = 1'b1;
    start = 1'b1;
    tick();
    ack   = 1'b0;
    start = 1'b0;
    check("as_done", int'(a_done), 0);
    check("as_busy", int'(a_busy), 1);
    check("as_sum", int'(a_sum), 0);
    check("as_cnt", int'(a_cnt), 0);
    for (int i = 1; i <= 4; i++) send(-100 * i, 1);
    pop("as_win");

    // ack then IDLE backpressure, then a fresh window
    ack = 1'b1;
    tick();
    ack          = 1'b0;
    sample_valid = 1'b1;
    repeat (5) tick();
    sample_valid = 1'b0;
    check("bp_idle_cnt", int'(a_cnt), 4);
    check("bp_idle_rdy", int'(a_rdy), 0);
    go();
    check("new_sum", int'(a_sum), 0);
    check("new_cnt", int'(a_cnt), 0);

    // positive overflow
    for (int i = 0; i < 4; i++) send(32767, 0);
    pop("ovf_wide");
    s = $signed(n_sum);
`ifdef ACC_SATURATE_EN
    check("ovf_pos", s, 65535);
`else
    check("ovf_pos", s, -4);
`endif
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // negative overflow
    go();
    for (int i = 0; i < 4; i++) send(-32768, 0);
    pop("ovf_wide_n");
    s = $signed(n_sum);
`ifdef ACC_SATURATE_EN
    check("ovf_neg", s, -65536);
`else
    check("ovf_neg", s, 0);
`endif
    check("ovf_done", int'(n_done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
